prog_exec: RTL and testbench

- Execution stage directly downstream of the 16-word, 5-bit instruction loader.
- Once the loader signals program-loaded, prog_exec runs the stored program. It drives the loader's read address, registers the returned word, then decodes and executes it on a 4-bit accumulator.
- Results leave through a valid/ready output port. Runs until HALT, or until clear.

---
 rtl/prog_exec.sv | 183 ++++++++++++++++++
 tb/tb_prog_exec.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_exec.sv
// Execution stage for the 16-word instruction loader: fetches, decodes and runs
// a stored program on a 4-bit accumulator, emitting results over valid/ready.
module prog_exec #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned INSTR_WIDTH = 5,
   parameter int unsigned ACC_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   clear,
   input  logic                   run,
   input  logic [INSTR_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0]  address,
   output logic [ACC_WIDTH-1:0]   data_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   carry,
   output logic                   zero,
   output logic                   busy,
   output logic                   halted
);

   localparam int unsigned OP_WIDTH  = 3;
   localparam int unsigned IMM_WIDTH = INSTR_WIDTH - OP_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WAIT_OUT,
      S_HALT
   } state_t;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_NOP  = 3'd0,
      OP_LDI  = 3'd1,
      OP_ADDI = 3'd2,
      OP_SUBI = 3'd3,
      OP_OUT  = 3'd4,
      OP_JNZ  = 3'd5,
      OP_SHF  = 3'd6,
      OP_HALT = 3'd7
   } op_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ACC_WIDTH-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   carry_q, carry_d;
   logic                   zero_q, zero_d;
   logic                   busy_q, busy_d;
   logic                   halted_q, halted_d;
   logic                   run_q;

   logic                   start;
   op_t                    op;
   logic [IMM_WIDTH-1:0]   imm;
   logic [ACC_WIDTH-1:0]   imm_ext;
   logic [ACC_WIDTH:0]     sum;

   assign start   = run & ~run_q;
   assign op      = op_t'(instr_q[INSTR_WIDTH-1 -: OP_WIDTH]);
   assign imm     = instr_q[IMM_WIDTH-1:0];
   assign imm_ext = ACC_WIDTH'(imm);

   // State and datapath registers; clear wins over everything.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         acc_q    <= '0;
         instr_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         acc_q    <= acc_d;
         instr_q  <= instr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         halted_q <= halted_d;
         run_q    <= run;
      end
   end

   // Next-state, decode and execute.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      instr_d = instr_q;
      data_d  = data_q;
      valid_d = valid_q;
      carry_d = carry_q;
      sum     = '0;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
               acc_d   = '0;
               carry_d = 1'b0;
            end
         end
         S_FETCH: begin
            instr_d = instruction;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
            case (op)
               OP_NOP: ;
               OP_LDI: acc_d = imm_ext;
               OP_ADDI: begin
                  sum     = {1'b0, acc_q} + {1'b0, imm_ext};
                  acc_d   = sum[ACC_WIDTH-1:0];
                  carry_d = sum[ACC_WIDTH];
               end
               OP_SUBI: begin
                  acc_d   = acc_q - imm_ext;
                  carry_d = (acc_q < imm_ext);
               end
               OP_OUT: begin
                  data_d  = acc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q;
                  state_d = S_WAIT_OUT;
               end
               OP_JNZ: begin
                  if (acc_q != '0) pc_d = pc_q - ADDR_WIDTH'(imm) - ADDR_WIDTH'(1);
               end
               OP_SHF: begin
                  if (imm[0]) begin
                     acc_d   = acc_q >> 1;
                     carry_d = acc_q[0];
                  end else begin
                     acc_d   = acc_q << 1;
                     carry_d = acc_q[ACC_WIDTH-1];
                  end
               end
               OP_HALT: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
            endcase
         end
         S_WAIT_OUT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + ADDR_WIDTH'(1);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // zero always tracks the accumulator it is registered with
      zero_d   = (acc_d == '0);
      busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WAIT_OUT);
      halted_d = (state_d == S_HALT);
   end

   assign address   = pc_q;
   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign busy      = busy_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_prog_exec.sv
// Bench for prog_exec: directed scenarios plus random programs checked against
// an instruction-level reference model of the accumulator machine.
module tb_prog_exec;

   logic       clk = 1'b0;
   logic       clear, run, out_ready;
   logic [4:0] instruction;
   logic [3:0] address, data_out;
   logic       out_valid, carry, zero, busy, halted;

   logic [4:0] mem [16];
   logic [3:0] exp_q [$];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   assign instruction = mem[address];

   prog_exec dut (
      .clk        (clk),
      .clear      (clear),
      .run        (run),
      .instruction(instruction),
      .address    (address),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .carry      (carry),
      .zero       (zero),
      .busy       (busy),
      .halted     (halted)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction-level model: runs the program in mem, records every OUT value.
   function automatic void iss(input int max_steps, output int steps, output bit hlt,
                               output int fpc, output int facc, output int fc);
      int pc, acc, c, op, imm, np;
      pc = 0; acc = 0; c = 0; steps = 0; hlt = 1'b0;
      exp_q.delete();
      while (steps < max_steps && !hlt) begin
         op  = int'(mem[pc]) / 4;
         imm = int'(mem[pc]) % 4;
         np  = (pc + 1) % 16;
         steps++;
         case (op)
            1: acc = imm;
            2: begin acc = acc + imm; c = (acc > 15) ? 1 : 0; acc = acc % 16; end
            3: begin c = (acc < imm) ? 1 : 0; acc = (acc - imm + 16) % 16; end
            4: exp_q.push_back(4'(acc));
            5: if (acc != 0) np = (pc - imm - 1 + 32) % 16;
            6: begin
               if (imm % 2 == 0) begin c = acc / 8; acc = (acc * 2) % 16; end
               else begin c = acc % 2; acc = acc / 2; end
            end
            7: begin hlt = 1'b1; np = pc; end
            default: ;
         endcase
         pc = np;
      end
      fpc = pc; facc = acc; fc = c;
   endfunction

   task automatic load_countdown();
      foreach (mem[i]) mem[i] = 5'h00;
      mem[0] = 5'h07; mem[1] = 5'h10; mem[2] = 5'h0D; mem[3] = 5'h15; mem[4] = 5'h1C;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1; run = 1'b0;
      @(negedge clk); clear = 1'b0;
   endtask

   task automatic start_run();
      @(negedge clk); run = 1'b0;
      @(negedge clk); run = 1'b1;
   endtask

   // Runs the program in mem with random backpressure and scores it against the model.
   task automatic run_prog(input int ready_pct);
      int n, fpc, facc, fc, k, w, budget;
      bit hlt, rdy, prev_stall;
      logic [3:0] prev_data, hold_pc;
      iss(400, n, hlt, fpc, facc, fc);
      budget = hlt ? (1 + 2 * n + 3000) : 150;
      k = 0; w = 0; prev_stall = 1'b0; prev_data = '0;
      start_run();
      while (1) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            check_eq("start_addr", address, 0);
            check_eq("start_carry", carry, 0);
            check_eq("start_zero", zero, 1);
         end
         if (halted || k >= budget) break;
         check_eq("busy", busy, 1);
         if (prev_stall) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", data_out, prev_data);
         end
         if (out_valid) w++;
         rdy = ($urandom_range(99) < ready_pct);
         out_ready = rdy;
         if (out_valid && rdy) begin
            if (exp_q.size() == 0) check_eq("extra_out", 1, 0);
            else check_eq("out_data", data_out, exp_q.pop_front());
         end
         prev_stall = out_valid && !rdy;
         prev_data  = data_out;
         if (k == 3 && $urandom_range(1) == 0) run = 1'b0;
      end
      if (hlt) begin
         check_eq("halted", halted, 1);
         check_eq("halt_cycle", k, 1 + 2 * n + w);
         check_eq("halt_addr", address, fpc);
         check_eq("halt_carry", carry, fc);
         check_eq("halt_zero", zero, (facc == 0) ? 1 : 0);
         check_eq("outs_left", exp_q.size(), 0);
         hold_pc = address;
         repeat (3) @(negedge clk);
         check_eq("hold_halted", halted, 1);
         check_eq("hold_addr", address, hold_pc);
      end else begin
         exp_q.delete();
         pulse_clear();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int exp_c [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
      clear = 1'b1; run = 1'b1; out_ready = 1'b0;
      load_countdown();

      // reset with run held high, then release: run_q=0 so execution starts
      repeat (2) @(negedge clk);
      check_eq("rst_addr", address, 0);
      check_eq("rst_data", data_out, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_carry", carry, 0);
      check_eq("rst_zero", zero, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_halted", halted, 0);
      clear = 1'b0;
      @(negedge clk);
      check_eq("rel_busy", busy, 1);
      check_eq("rel_addr", address, 0);
      pulse_clear();

      // countdown with free-flowing consumer
      run_prog(100);
      check_eq("cd_addr", address, 4);
      check_eq("cd_zero", zero, 1);

      // backpressure on the first OUT
      out_ready = 1'b0;
      start_run();
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 20);
      repeat (5) begin
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_data", data_out, 3);
         check_eq("bp_addr", address, 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_drop", out_valid, 0);
      check_eq("bp_adv", address, 2);
      t = 0;
      while (!halted && t < 60) begin @(negedge clk); t++; end
      check_eq("bp_halted", halted, 1);
      check_eq("bp_haddr", address, 4);

      // arithmetic flags
      foreach (mem[i]) mem[i] = 5'h00;
      mem[0] = 5'h07;
      for (int i = 1; i <= 5; i++) mem[i] = 5'h0B;
      mem[6] = 5'h0F; mem[7] = 5'h18;
      start_run();
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k >= 3 && (k % 2) == 1) begin
            check_eq("ar_carry", carry, exp_c[(k - 3) / 2]);
            check_eq("ar_zero", zero, 0);
         end
      end
      pulse_clear();

      // pc wrap-around over 16 NOPs
      foreach (mem[i]) mem[i] = 5'h00;
      start_run();
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         check_eq("wr_addr", address, ((k - 1) / 2) % 16);
         check_eq("wr_busy", busy, 1);
         check_eq("wr_valid", out_valid, 0);
      end
      pulse_clear();

      // clear while stalled in WAIT_OUT
      load_countdown();
      out_ready = 1'b0;
      start_run();
      t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 20);
      check_eq("mr_valid", out_valid, 1);
      clear = 1'b1; run = 1'b0;
      @(negedge clk);
      check_eq("mr_drop", out_valid, 0);
      check_eq("mr_busy", busy, 0);
      check_eq("mr_addr", address, 0);
      check_eq("mr_data", data_out, 0);
      clear = 1'b0;
      run_prog(100);

      // halt with carry set, then restart must clear it
      foreach (mem[i]) mem[i] = 5'h00;
      mem[0] = 5'h04; mem[1] = 5'h0D; mem[2] = 5'h1C;
      run_prog(100);
      check_eq("rs_carry", carry, 1);
      run_prog(70);

      // random programs
      repeat (30) begin
         foreach (mem[i]) mem[i] = 5'($urandom_range(31));
         run_prog(int'($urandom_range(100, 30)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
